inst_queue: RTL and testbench

Dual-issue instruction queue between fetch and the decode stage. Accepts up to two in-order instructions per cycle from fetch and presents the two oldest entries as the decoder's slot-0/slot-1 inputs. Pops them when the decoder accepts the pair. Absorbs decoder stalls and fetch bubbles, and is emptied on pipeline flush from writeback.

---
 rtl/kiwi_pkg.sv | 20 ++
 rtl/inst_queue_if.sv | 64 ++++++
 rtl/inst_queue.sv | 120 ++++++++++++
 tb/tb_inst_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/kiwi_pkg.sv
// -----------------------------------------------------------------------------
// kiwi_pkg
// Shared core-wide definitions used by the front-end blocks.
//   XLEN      : architectural register / PC width
//   ILEN      : instruction width
//   IQ_DEPTH  : default instruction-queue depth (power of two, >= 4)
//   iq_entry_t: one instruction-queue entry {pc, inst}
// -----------------------------------------------------------------------------
package kiwi_pkg;

   localparam int XLEN     = 64;
   localparam int ILEN     = 32;
   localparam int IQ_DEPTH = 8;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
   } iq_entry_t;

endpackage : kiwi_pkg

// File: rtl/inst_queue_if.sv
// -----------------------------------------------------------------------------
// inst_queue_if
// Bundles the fetch-side packet, the decoder-side slot pair, the flush from
// writeback and the occupancy report of the instruction queue.
//   master : the surrounding pipeline (fetch, decode, writeback)
//   slave  : the instruction queue itself
// Signals:
//   flush_i                       flush from writeback
//   fetch_valid0/1_i, pc0/1, inst0/1   2-wide in-order fetch packet
//   fetch_ready_o                 queue can take a full 2-wide packet
//   deq_ready_i                   decoder accepts the presented pair
//   inst0/1_f1_valid/pc/inst_o    oldest / second-oldest entries
//   count_o                       current occupancy
// -----------------------------------------------------------------------------
interface inst_queue_if #(
   parameter int DEPTH = kiwi_pkg::IQ_DEPTH
);
   import kiwi_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   logic            flush_i;

   logic            fetch_valid0_i;
   logic [XLEN-1:0] fetch_pc0_i;
   logic [ILEN-1:0] fetch_inst0_i;
   logic            fetch_valid1_i;
   logic [XLEN-1:0] fetch_pc1_i;
   logic [ILEN-1:0] fetch_inst1_i;
   logic            fetch_ready_o;

   logic            deq_ready_i;
   logic            inst0_f1_valid_o;
   logic [XLEN-1:0] inst0_f1_pc_o;
   logic [ILEN-1:0] inst0_f1_inst_o;
   logic            inst1_f1_valid_o;
   logic [XLEN-1:0] inst1_f1_pc_o;
   logic [ILEN-1:0] inst1_f1_inst_o;

   logic [CW-1:0]   count_o;

   modport master (
      output flush_i,
      output fetch_valid0_i, fetch_pc0_i, fetch_inst0_i,
      output fetch_valid1_i, fetch_pc1_i, fetch_inst1_i,
      input  fetch_ready_o,
      output deq_ready_i,
      input  inst0_f1_valid_o, inst0_f1_pc_o, inst0_f1_inst_o,
      input  inst1_f1_valid_o, inst1_f1_pc_o, inst1_f1_inst_o,
      input  count_o
   );

   modport slave (
      input  flush_i,
      input  fetch_valid0_i, fetch_pc0_i, fetch_inst0_i,
      input  fetch_valid1_i, fetch_pc1_i, fetch_inst1_i,
      output fetch_ready_o,
      input  deq_ready_i,
      output inst0_f1_valid_o, inst0_f1_pc_o, inst0_f1_inst_o,
      output inst1_f1_valid_o, inst1_f1_pc_o, inst1_f1_inst_o,
      output count_o
   );

endinterface : inst_queue_if

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Dual-issue instruction queue between fetch and decode. Accepts up to two
// in-order instructions per cycle, presents the two oldest entries to the
// decoder as slot 0 / slot 1, pops them when the decoder accepts, and is
// emptied by a writeback flush.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (pointers only; storage is not reset)
//   iq     inst_queue_if.slave (fetch packet, decoder pair, flush, count)
// -----------------------------------------------------------------------------
module inst_queue
   import kiwi_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   inst_queue_if.slave   iq
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Storage is a flop array: two entries are read combinationally each cycle.
   iq_entry_t        mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW-1:0]    head_nxt;
   logic [PW-1:0]    tail_nxt;
   logic [PW-1:0]    count;

   logic [AW-1:0]    head_idx0;
   logic [AW-1:0]    head_idx1;
   logic [AW-1:0]    tail_idx0;
   logic [AW-1:0]    tail_idx1;

   logic             ready;
   logic             valid0;
   logic             valid1;
   logic             enq;
   logic             deq;
   logic [PW-1:0]    enq_n;
   logic [PW-1:0]    deq_n;

   iq_entry_t        rd0;
   iq_entry_t        rd1;

   // ---- occupancy and handshake, from registered pointers only ----
   assign count  = tail - head;
   // Start-of-cycle occupancy only: a same-cycle pop is not credited, which
   // keeps deq_ready_i out of the fetch_ready_o path.
   assign ready  = (count <= PW'(DEPTH - 2));
   assign valid0 = (count != '0);
   assign valid1 = (count >= PW'(2));

   // A lone slot-1 valid is illegal and enqueues nothing.
   assign enq    = ready & iq.fetch_valid0_i & ~iq.flush_i;
   assign deq    = iq.deq_ready_i & valid0 & ~iq.flush_i;
   assign enq_n  = iq.fetch_valid1_i ? PW'(2) : PW'(1);
   assign deq_n  = valid1 ? PW'(2) : PW'(1);

   // Low pointer bits index storage; the +1 neighbours wrap DEPTH-1 -> 0.
   assign head_idx0 = head[AW-1:0];
   assign head_idx1 = head[AW-1:0] + AW'(1);
   assign tail_idx0 = tail[AW-1:0];
   assign tail_idx1 = tail[AW-1:0] + AW'(1);

   always_comb begin
      head_nxt = head;
      tail_nxt = tail;
      if (iq.flush_i) begin
         head_nxt = '0;
         tail_nxt = '0;
      end else begin
         if (enq) tail_nxt = tail + enq_n;
         if (deq) head_nxt = head + deq_n;
      end
   end

   // ---- pointer registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
      end else begin
         head <= head_nxt;
         tail <= tail_nxt;
      end
   end

   // ---- storage write ----
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail_idx0] <= '{pc: iq.fetch_pc0_i, inst: iq.fetch_inst0_i};
         if (iq.fetch_valid1_i) begin
            mem[tail_idx1] <= '{pc: iq.fetch_pc1_i, inst: iq.fetch_inst1_i};
         end
      end
   end

   // ---- decoder-side read ----
   assign rd0 = mem[head_idx0];
   assign rd1 = mem[head_idx1];

   assign iq.fetch_ready_o    = ready;
   assign iq.count_o          = count;

   // Data is forced to zero whenever its slot is not valid, so stale storage
   // (including after flush or reset) never leaks onto the decoder inputs.
   assign iq.inst0_f1_valid_o = valid0;
   assign iq.inst0_f1_pc_o    = valid0 ? rd0.pc   : '0;
   assign iq.inst0_f1_inst_o  = valid0 ? rd0.inst : '0;
   assign iq.inst1_f1_valid_o = valid1;
   assign iq.inst1_f1_pc_o    = valid1 ? rd1.pc   : '0;
   assign iq.inst1_f1_inst_o  = valid1 ? rd1.inst : '0;

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
// Directed bench for inst_queue (DEPTH = 8) with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_inst_queue;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   inst_queue_if #(.DEPTH(8)) bus ();

   inst_queue #(.DEPTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .iq    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch2(input logic [63:0] p0, input logic [31:0] i0,
                         input logic [63:0] p1, input logic [31:0] i1);
      bus.fetch_valid0_i = 1'b1; bus.fetch_pc0_i = p0; bus.fetch_inst0_i = i0;
      bus.fetch_valid1_i = 1'b1; bus.fetch_pc1_i = p1; bus.fetch_inst1_i = i1;
   endtask

   task automatic fetch1(input logic [63:0] p0, input logic [31:0] i0);
      bus.fetch_valid0_i = 1'b1; bus.fetch_pc0_i = p0; bus.fetch_inst0_i = i0;
      bus.fetch_valid1_i = 1'b0; bus.fetch_pc1_i = '0; bus.fetch_inst1_i = '0;
   endtask

   task automatic fetch_off();
      bus.fetch_valid0_i = 1'b0;
      bus.fetch_valid1_i = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.flush_i = 1'b0;
      bus.deq_ready_i = 1'b0;
      bus.fetch_pc0_i = '0; bus.fetch_inst0_i = '0;
      bus.fetch_pc1_i = '0; bus.fetch_inst1_i = '0;
      fetch_off();

      // Reset state
      #1;
      chk("rst_count",  bus.count_o, 0);
      chk("rst_v0",     bus.inst0_f1_valid_o, 0);
      chk("rst_v1",     bus.inst1_f1_valid_o, 0);
      chk("rst_pc0",    bus.inst0_f1_pc_o, 0);
      chk("rst_inst1",  bus.inst1_f1_inst_o, 0);
      chk("rst_ready",  bus.fetch_ready_o, 1);
      #10 rst_n = 1'b1;
      step();

      // First 2-wide packet: no bypass, visible one cycle later
      fetch2(64'h1000, 32'h0000_0013, 64'h1004, 32'h0050_0093);
      #1;
      chk("nobypass_v0", bus.inst0_f1_valid_o, 0);
      step();
      fetch_off();
      chk("p1_v0",    bus.inst0_f1_valid_o, 1);
      chk("p1_pc0",   bus.inst0_f1_pc_o, 64'h1000);
      chk("p1_inst0", bus.inst0_f1_inst_o, 32'h0000_0013);
      chk("p1_v1",    bus.inst1_f1_valid_o, 1);
      chk("p1_pc1",   bus.inst1_f1_pc_o, 64'h1004);
      chk("p1_inst1", bus.inst1_f1_inst_o, 32'h0050_0093);
      chk("p1_count", bus.count_o, 2);

      // Fill with deq held off
      fetch2(64'h1008, 32'h11, 64'h100c, 32'h12);
      step();
      chk("fill_count4", bus.count_o, 4);
      fetch2(64'h1010, 32'h21, 64'h1014, 32'h22);
      step();
      chk("fill_count6", bus.count_o, 6);
      chk("fill_ready6", bus.fetch_ready_o, 1);
      fetch1(64'h1018, 32'h31);
      step();
      chk("fill_count7", bus.count_o, 7);
      chk("fill_ready7", bus.fetch_ready_o, 0);
      fetch2(64'h1020, 32'h41, 64'h1024, 32'h42);
      step();
      chk("drop_count", bus.count_o, 7);
      chk("drop_ready", bus.fetch_ready_o, 0);

      // Pop while fetch waits: dequeue is not credited to fetch_ready_o
      bus.deq_ready_i = 1'b1;
      step();
      chk("nocredit_count", bus.count_o, 5);
      chk("nocredit_pc0",   bus.inst0_f1_pc_o, 64'h1008);
      chk("nocredit_pc1",   bus.inst1_f1_pc_o, 64'h100c);
      chk("nocredit_ready", bus.fetch_ready_o, 1);

      // Simultaneous enqueue (entries 7,0) and dequeue (entries 2,3)
      step();
      fetch_off();
      chk("simul_count", bus.count_o, 5);
      chk("simul_pc0",   bus.inst0_f1_pc_o, 64'h1010);
      chk("simul_inst1", bus.inst1_f1_inst_o, 32'h22);

      step();
      chk("pop_count3", bus.count_o, 3);
      chk("pop_pc0_e6", bus.inst0_f1_pc_o, 64'h1018);
      chk("pop_pc1_e7", bus.inst1_f1_pc_o, 64'h1020);

      // Three entries: pops 2 then the lone one
      step();
      chk("pop2_count", bus.count_o, 1);
      chk("pop2_pc0",   bus.inst0_f1_pc_o, 64'h1024);
      chk("pop2_inst0", bus.inst0_f1_inst_o, 32'h42);
      chk("pop2_v1",    bus.inst1_f1_valid_o, 0);
      chk("pop2_pc1",   bus.inst1_f1_pc_o, 0);
      step();
      chk("pop1_count", bus.count_o, 0);
      chk("pop1_v0",    bus.inst0_f1_valid_o, 0);
      chk("pop1_pc0",   bus.inst0_f1_pc_o, 0);
      step();
      chk("empty_deq_count", bus.count_o, 0);
      bus.deq_ready_i = 1'b0;

      // Flush with fetch and deq active at count 5
      fetch2(64'h5000, 32'h51, 64'h5004, 32'h52);
      step();
      fetch2(64'h5008, 32'h53, 64'h500c, 32'h54);
      step();
      fetch1(64'h5010, 32'h55);
      step();
      chk("preflush_count", bus.count_o, 5);
      fetch2(64'h5014, 32'h56, 64'h5018, 32'h57);
      bus.deq_ready_i = 1'b1;
      bus.flush_i     = 1'b1;
      step();
      bus.flush_i     = 1'b0;
      bus.deq_ready_i = 1'b0;
      fetch_off();
      chk("flush_count", bus.count_o, 0);
      chk("flush_v0",    bus.inst0_f1_valid_o, 0);
      chk("flush_v1",    bus.inst1_f1_valid_o, 0);
      chk("flush_ready", bus.fetch_ready_o, 1);

      // Wrap: move head=tail to 6, then entries 6,7 with tail wrapping to 0
      for (int i = 0; i < 3; i++) begin
         fetch2(64'h6000 + 64'(16 * i), 32'h60, 64'h6008 + 64'(16 * i), 32'h61);
         step();
      end
      fetch_off();
      bus.deq_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      bus.deq_ready_i = 1'b0;
      chk("wrap_pre_count", bus.count_o, 0);
      fetch2(64'h2000, 32'hA0, 64'h2004, 32'hA1);
      step();
      fetch_off();
      chk("wrap_count", bus.count_o, 2);
      chk("wrap_pc0_e6", bus.inst0_f1_pc_o, 64'h2000);
      chk("wrap_inst0",  bus.inst0_f1_inst_o, 32'hA0);
      chk("wrap_pc1_e7", bus.inst1_f1_pc_o, 64'h2004);
      chk("wrap_inst1",  bus.inst1_f1_inst_o, 32'hA1);
      bus.deq_ready_i = 1'b1;
      step();
      bus.deq_ready_i = 1'b0;
      chk("wrap_pop_count", bus.count_o, 0);
      fetch2(64'h3000, 32'hB0, 64'h3004, 32'hB1);
      step();
      fetch_off();
      chk("wrapped_pc0_e0", bus.inst0_f1_pc_o, 64'h3000);
      chk("wrapped_pc1_e1", bus.inst1_f1_pc_o, 64'h3004);

      // Async reset mid-stream with count 4
      fetch2(64'h3008, 32'hB2, 64'h300c, 32'hB3);
      step();
      fetch_off();
      chk("prerst_count", bus.count_o, 4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", bus.count_o, 0);
      chk("arst_v0",    bus.inst0_f1_valid_o, 0);
      chk("arst_pc0",   bus.inst0_f1_pc_o, 0);
      chk("arst_pc1",   bus.inst1_f1_pc_o, 0);
      chk("arst_ready", bus.fetch_ready_o, 1);
      step();
      rst_n = 1'b1;

      // head+1 read wrapping 7 -> 0: bring head to 7, then entries 7 and 0
      for (int i = 0; i < 3; i++) begin
         fetch2(64'h7000 + 64'(16 * i), 32'h70, 64'h7008 + 64'(16 * i), 32'h71);
         step();
      end
      fetch_off();
      bus.deq_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) step();
      bus.deq_ready_i = 1'b0;
      fetch1(64'h7100, 32'h72);
      step();
      fetch_off();
      bus.deq_ready_i = 1'b1;
      step();
      bus.deq_ready_i = 1'b0;
      fetch2(64'h8000, 32'hC0, 64'h8004, 32'hC1);
      step();
      fetch_off();
      chk("hw_count",  bus.count_o, 2);
      chk("hw_pc0_e7", bus.inst0_f1_pc_o, 64'h8000);
      chk("hw_pc1_e0", bus.inst1_f1_pc_o, 64'h8004);
      chk("hw_inst1",  bus.inst1_f1_inst_o, 32'hC1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_inst_queue
